// File: rtl/gate_ctrl.sv
// Parking-lot gate controller: resynchronises FreqDiv's 1 Hz / 2 Hz clocks into
// one-cycle ticks and sequences entry/exit gating, occupancy and timeout alarm.
module gate_ctrl #(
    parameter int CAPACITY = 8,
    parameter int OPEN_SEC = 5,
    parameter int COUNT_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_1Hz,
    input  logic               clk_2Hz,
    input  logic               entry_req,
    input  logic               exit_req,
    input  logic               pass_sensor,
    input  logic               alarm_clr,
    output logic               gate_open,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic               deny,
    output logic               lamp,
    output logic               alarm,
    output logic               sec_tick
);

    localparam int TIMER_W = $clog2(OPEN_SEC + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ENTRY = 2'd1;
    localparam logic [1:0] S_EXIT  = 2'd2;
    localparam logic [1:0] S_ALARM = 2'd3;

    localparam logic [COUNT_W-1:0] CAP_C      = COUNT_W'(CAPACITY);
    localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(OPEN_SEC);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

    // Tick paths: two synchroniser flops, a delay flop and a registered edge pulse.
    logic sec_sync1_q, sec_sync2_q, sec_prev_q, sec_tick_q;
    logic half_sync1_q, half_sync2_q, half_prev_q, half_tick_q;
    logic pass_q;
    logic pass_evt;

    logic [1:0]         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               full_q, full_d;
    logic               deny_q, deny_d;
    logic [2:0]         deny_cnt_q, deny_cnt_d;
    logic               lamp_q, lamp_d;
    logic               gate_q, alarm_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sec_sync1_q  <= 1'b0;
            sec_sync2_q  <= 1'b0;
            sec_prev_q   <= 1'b0;
            sec_tick_q   <= 1'b0;
            half_sync1_q <= 1'b0;
            half_sync2_q <= 1'b0;
            half_prev_q  <= 1'b0;
            half_tick_q  <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sec_sync1_q  <= clk_1Hz;
            sec_sync2_q  <= sec_sync1_q;
            sec_prev_q   <= sec_sync2_q;
            sec_tick_q   <= sec_sync2_q & ~sec_prev_q;
            half_sync1_q <= clk_2Hz;
            half_sync2_q <= half_sync1_q;
            half_prev_q  <= half_sync2_q;
            half_tick_q  <= half_sync2_q & ~half_prev_q;
            pass_q       <= pass_sensor;
        end
    end

    assign pass_evt = pass_sensor & ~pass_q;

    always_comb begin
        // NOTE: every next-state signal gets a default here so no latch is inferred.
        state_d    = state_q;
        timer_d    = timer_q;
        count_d    = count_q;
        deny_d     = 1'b0;
        deny_cnt_d = 3'd0;
        case (state_q)
            S_IDLE: begin
                if (exit_req && (count_q != '0)) begin
                    state_d = S_EXIT;
                    timer_d = TIMER_LOAD;
                end else if (entry_req && !full_q) begin
                    state_d = S_ENTRY;
                    timer_d = TIMER_LOAD;
                end else if (entry_req) begin
                    // Refused entry re-pulses deny every 8 cycles while held.
                    deny_d     = (deny_cnt_q == 3'd0);
                    deny_cnt_d = deny_cnt_q + 3'd1;
                end
            end
            S_ENTRY, S_EXIT: begin
                if (pass_evt) begin
                    state_d = S_IDLE;
                    if (state_q == S_ENTRY) begin
                        if (count_q < CAP_C) count_d = count_q + COUNT_ONE;
                    end else if (count_q != '0) begin
                        count_d = count_q - COUNT_ONE;
                    end
                end else if (sec_tick_q) begin
                    if (timer_q == TIMER_ONE) state_d = S_ALARM;
                    else                      timer_d = timer_q - TIMER_ONE;
                end
            end
            S_ALARM: begin
                if (alarm_clr) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        full_d = (count_d == CAP_C);
        // Steady full indication while idle; 1 Hz blink everywhere else.
        if (state_d == S_IDLE)  lamp_d = full_d;
        else if (half_tick_q)   lamp_d = ~lamp_q;
        else                    lamp_d = lamp_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            deny_q     <= 1'b0;
            deny_cnt_q <= 3'd0;
            lamp_q     <= 1'b0;
            gate_q     <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            count_q    <= count_d;
            full_q     <= full_d;
            deny_q     <= deny_d;
            deny_cnt_q <= deny_cnt_d;
            lamp_q     <= lamp_d;
            gate_q     <= (state_d == S_ENTRY) || (state_d == S_EXIT);
            alarm_q    <= (state_d == S_ALARM);
        end
    end

    assign gate_open = gate_q;
    assign count     = count_q;
    assign full      = full_q;
    assign deny      = deny_q;
    assign lamp      = lamp_q;
    assign alarm     = alarm_q;
    assign sec_tick  = sec_tick_q;

endmodule

// File: tb/tb_gate_ctrl.sv
// Bench for gate_ctrl: cycle-level behavioural model compared on every falling
// edge, plus directed scenarios with hand-computed expectations.
module tb_gate_ctrl;

    localparam int CAPACITY = 8;
    localparam int OPEN_SEC = 5;
    localparam int COUNT_W  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clk_1Hz, clk_2Hz;
    logic entry_req = 1'b0, exit_req = 1'b0, pass_sensor = 1'b0, alarm_clr = 1'b0;
    logic gate_open, full, deny, lamp, alarm, sec_tick;
    logic [COUNT_W-1:0] count;

    logic man_1hz = 1'b0;
    logic gen_1hz = 1'b0, gen_2hz = 1'b0;
    logic freq_en = 1'b0;
    int   phase   = 0;

    int n_cmp = 0;
    int n_err = 0;

    assign clk_1Hz = freq_en ? gen_1hz : man_1hz;
    assign clk_2Hz = freq_en & gen_2hz;

    always #5 clk = ~clk;

    gate_ctrl #(.CAPACITY(CAPACITY), .OPEN_SEC(OPEN_SEC), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .reset(reset), .clk_1Hz(clk_1Hz), .clk_2Hz(clk_2Hz),
        .entry_req(entry_req), .exit_req(exit_req), .pass_sensor(pass_sensor),
        .alarm_clr(alarm_clr), .gate_open(gate_open), .count(count), .full(full),
        .deny(deny), .lamp(lamp), .alarm(alarm), .sec_tick(sec_tick)
    );

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Stand-in for FreqDiv: 40-cycle "second", 2 Hz edges halfway between 1 Hz edges.
    initial forever begin
        @(negedge clk);
        if (freq_en) begin
            phase   = (phase + 1) % 40;
            gen_1hz = (phase >= 20);
            gen_2hz = ((phase % 20) >= 10);
        end
    end

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_ENTRY, M_EXIT, M_ALARM} mode_t;
    mode_t m_mode;
    int    m_timer, m_count, m_deny_run;
    logic  m_gate, m_full, m_deny, m_lamp, m_alarm, m_sec_tick, m_half_tick, m_pass_prev;
    logic [3:0] h1, h2;

    task model_reset();
        m_mode = M_IDLE; m_timer = 0; m_count = 0; m_deny_run = 0;
        m_gate = 0; m_full = 0; m_deny = 0; m_lamp = 0; m_alarm = 0;
        m_sec_tick = 0; m_half_tick = 0; m_pass_prev = 0;
        h1 = '0; h2 = '0;
    endtask

    task model_step();
        logic p_evt;
        p_evt = pass_sensor && !m_pass_prev;
        m_pass_prev = pass_sensor;
        m_deny = 0;
        case (m_mode)
            M_IDLE: begin
                if (exit_req && m_count > 0) begin
                    m_mode = M_EXIT; m_timer = OPEN_SEC; m_deny_run = 0;
                end else if (entry_req && m_count < CAPACITY) begin
                    m_mode = M_ENTRY; m_timer = OPEN_SEC; m_deny_run = 0;
                end else if (entry_req) begin
                    m_deny = (m_deny_run % 8 == 0);
                    m_deny_run++;
                end else begin
                    m_deny_run = 0;
                end
            end
            M_ENTRY, M_EXIT: begin
                m_deny_run = 0;
                if (p_evt) begin
                    m_count += (m_mode == M_ENTRY) ? 1 : -1;
                    if (m_count > CAPACITY) m_count = CAPACITY;
                    if (m_count < 0) m_count = 0;
                    m_mode = M_IDLE;
                end else if (m_sec_tick) begin
                    m_timer--;
                    if (m_timer == 0) m_mode = M_ALARM;
                end
            end
            default: begin
                m_deny_run = 0;
                if (alarm_clr) m_mode = M_IDLE;
            end
        endcase
        m_full  = (m_count == CAPACITY);
        m_gate  = (m_mode == M_ENTRY) || (m_mode == M_EXIT);
        m_alarm = (m_mode == M_ALARM);
        if (m_mode == M_IDLE) m_lamp = m_full;
        else if (m_half_tick)  m_lamp = !m_lamp;
        // Tick appears in the third cycle after the one where the rising level is sampled.
        h1 = {h1[2:0], clk_1Hz};
        h2 = {h2[2:0], clk_2Hz};
        m_sec_tick  = h1[2] && !h1[3];
        m_half_tick = h2[2] && !h2[3];
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else       model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        check("gate_open", gate_open, m_gate);
        check("count", count, m_count);
        check("full", full, m_full);
        check("deny", deny, m_deny);
        check("lamp", lamp, m_lamp);
        check("alarm", alarm, m_alarm);
        check("sec_tick", sec_tick, m_sec_tick);
    end

    // ---------------- directed stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns on the falling edge where the n-th tick (counting the current edge) is visible.
    task automatic wait_ticks(input int n, input string what);
        int seen = m_sec_tick ? 1 : 0;
        int budget = 100 * n + 100;
        while (seen < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if (m_sec_tick) seen++;
        end
        check(what, seen, n);
    endtask

    task automatic count_toggles(input int n, output int toggles);
        logic prev = lamp;
        toggles = 0;
        repeat (n) begin
            @(negedge clk);
            if (lamp != prev) toggles++;
            prev = lamp;
        end
    endtask

    task automatic pass_pulse();
        pass_sensor = 1'b1;
        cycles(1);
        pass_sensor = 1'b0;
    endtask

    task automatic do_entry(input int ticks, input int exp_count);
        entry_req = 1'b1;
        cycles(1);
        entry_req = 1'b0;
        check("entry_gate_opened", gate_open, 1);
        if (ticks > 0) begin
            wait_ticks(ticks, "entry_ticks");
            cycles(1);
        end
        check("entry_no_alarm", alarm, 0);
        pass_pulse();
        check("entry_gate_closed", gate_open, 0);
        check("entry_count", count, exp_count);
        cycles(1);
    endtask

    task automatic do_exit(input int exp_count);
        exit_req = 1'b1;
        cycles(1);
        exit_req = 1'b0;
        check("exit_gate_opened", gate_open, 1);
        cycles(2);
        pass_pulse();
        check("exit_gate_closed", gate_open, 0);
        check("exit_count", count, exp_count);
        cycles(1);
    endtask

    initial begin
        int toggles;
        int deny_pulses;
        int gate_seen;

        // Reset held for 50 ns with the clock running.
        #40;
        check("rst_gate_open", gate_open, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_deny", deny, 0);
        check("rst_lamp", lamp, 0);
        check("rst_alarm", alarm, 0);
        check("rst_sec_tick", sec_tick, 0);
        #10;
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("no_tick_low_1hz", sec_tick, 0);
        end

        // Tick latency: rising level sampled at the next edge, tick in the third cycle after.
        man_1hz = 1'b1;
        cycles(1); check("tick_lat_c1", sec_tick, 0);
        cycles(1); check("tick_lat_c2", sec_tick, 0);
        cycles(1); check("tick_lat_c3", sec_tick, 1);
        cycles(1); check("tick_lat_c4", sec_tick, 0);
        cycles(4);
        man_1hz = 1'b0;
        cycles(6);

        freq_en = 1'b1;
        cycles(5);

        // First entry also measures the blink rate: two toggles per 40-cycle second.
        entry_req = 1'b1;
        cycles(1);
        entry_req = 1'b0;
        check("e1_gate_opened", gate_open, 1);
        count_toggles(40, toggles);
        check("lamp_toggles_open", toggles, 2);
        wait_ticks(1, "e1_tick");
        cycles(1);
        pass_pulse();
        check("e1_gate_closed", gate_open, 0);
        check("e1_count", count, 1);
        cycles(1);

        for (int i = 2; i <= CAPACITY; i++) do_entry(2, i);
        check("cap_count", count, 8);
        check("cap_full", full, 1);
        check("cap_lamp", lamp, 1);

        // Ninth car held for 20 cycles: deny pulses at offsets 0, 8, 16.
        deny_pulses = 0;
        gate_seen = 0;
        entry_req = 1'b1;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            if (i == 19) entry_req = 1'b0;
            if (deny) deny_pulses++;
            if (gate_open) gate_seen++;
        end
        check("deny_pulses", deny_pulses, 3);
        check("deny_gate_closed", gate_seen, 0);
        check("deny_count", count, 8);

        for (int c = 7; c >= 3; c--) do_exit(c);

        // Entry and exit together: exit wins.
        entry_req = 1'b1;
        exit_req  = 1'b1;
        cycles(1);
        entry_req = 1'b0;
        exit_req  = 1'b0;
        check("prio_gate_opened", gate_open, 1);
        cycles(2);
        pass_pulse();
        check("prio_count", count, 2);
        cycles(1);

        // Timeout with count 2: alarm only after the fifth tick.
        entry_req = 1'b1;
        cycles(1);
        entry_req = 1'b0;
        wait_ticks(5, "timeout_ticks");
        check("timeout_pre_alarm", alarm, 0);
        check("timeout_pre_gate", gate_open, 1);
        cycles(1);
        check("timeout_alarm", alarm, 1);
        check("timeout_gate", gate_open, 0);
        check("timeout_count", count, 2);
        count_toggles(40, toggles);
        check("lamp_toggles_alarm", toggles, 2);
        pass_pulse();
        cycles(1);
        check("alarm_pass_ignored", count, 2);
        check("alarm_still_set", alarm, 1);
        alarm_clr = 1'b1;
        cycles(1);
        alarm_clr = 1'b0;
        check("alarm_cleared", alarm, 0);
        cycles(2);

        do_exit(1);
        do_exit(0);

        // Exit with an empty lot is ignored.
        gate_seen = 0;
        exit_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gate_open) gate_seen++;
        end
        exit_req = 1'b0;
        check("empty_exit_ignored", gate_seen, 0);
        check("empty_exit_count", count, 0);

        // Pass coincident with the final tick: pass wins.
        entry_req = 1'b1;
        cycles(1);
        entry_req = 1'b0;
        wait_ticks(5, "coinc_ticks");
        pass_pulse();
        check("coinc_no_alarm", alarm, 0);
        check("coinc_count", count, 1);
        check("coinc_gate", gate_open, 0);
        cycles(3);
        check("coinc_no_alarm_later", alarm, 0);

        for (int i = 2; i <= 4; i++) do_entry(0, i);

        // Asynchronous reset while the gate is open with four cars parked.
        entry_req = 1'b1;
        cycles(1);
        entry_req = 1'b0;
        check("pre_rst_gate", gate_open, 1);
        check("pre_rst_count", count, 4);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_gate", gate_open, 0);
        check("async_rst_count", count, 0);
        check("async_rst_lamp", lamp, 0);
        cycles(3);
        reset = 1'b0;
        cycles(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gate_ctrl.md
Name: gate_ctrl

Overview:
- Parking-lot gate controller, directly downstream of FreqDiv; consumes its clk_1Hz and clk_2Hz outputs as timing references.
- Runs on the system clock and converts the divided clocks into one-cycle ticks.
- Sequences gate open/close for entry and exit, tracks lot occupancy, and raises a timeout alarm when a car does not pass.

Parameters:
- CAPACITY, 8, number of parking slots.
- OPEN_SEC, 5, seconds the gate stays open waiting for a pass event; must be ≥1.
- COUNT_W, 4, width of the occupancy count; must satisfy 2^COUNT_W > CAPACITY.

Ports:
- clk  in  1  system clock, same clock that drives FreqDiv.
- reset  in  1  asynchronous, active-high reset.
- clk_1Hz  in  1  divided clock from FreqDiv; treated as asynchronous data.
- clk_2Hz  in  1  divided clock from FreqDiv; treated as asynchronous data.
- entry_req  in  1  car at entry; level, synchronous to clk.
- exit_req  in  1  car at exit; level, synchronous to clk.
- pass_sensor  in  1  car passing under the gate; synchronous to clk.
- alarm_clr  in  1  operator acknowledge; synchronous pulse.
- gate_open  out  1  gate actuator; 1 = open.
- count  out  COUNT_W  occupied slots.
- full  out  1  count == CAPACITY.
- deny  out  1  one-cycle pulse when an entry is refused.
- lamp  out  1  status lamp.
- alarm  out  1  timeout alarm.
- sec_tick  out  1  one-cycle 1 Hz tick, exported for debug and verification.

Behaviour:
- Reset is asynchronous, active-high; one clock. Reset values:
  - state IDLE.
  - count=0, full=0, gate_open=0, deny=0, lamp=0, alarm=0, sec_tick=0.
  - timer=0; all synchronizer and edge flops 0.
- Tick generation:
  - Each of clk_1Hz and clk_2Hz passes through a 2-flop synchronizer and a registered edge detector.
  - A tick is high for exactly one clk cycle, 3 clk cycles after the cycle in which the rising input is first sampled.
  - sec_tick comes from clk_1Hz; half_tick is internal and comes from clk_2Hz.
  - An input held high across reset release produces one tick.
  - pass_sensor is registered once; pass_evt is its rising edge, one cycle wide.
- States: IDLE, ENTRY_OPEN, EXIT_OPEN, ALARM.
- IDLE:
  - exit_req && count>0 → EXIT_OPEN.
  - Else entry_req && !full → ENTRY_OPEN.
  - Else entry_req && full → stay in IDLE; deny pulses for 1 cycle, re-pulsing every 8 cycles while entry_req is held.
  - exit_req with count==0 is ignored.
  - When exit_req and entry_req are both high, exit wins.
- Entering ENTRY_OPEN or EXIT_OPEN: timer←OPEN_SEC, gate_open=1 from the next cycle.
- ENTRY_OPEN / EXIT_OPEN:
  - pass_evt → count +1 (entry) or −1 (exit), next state IDLE, gate_open=0 in the cycle after.
  - Else sec_tick with timer==1 → ALARM.
  - Else sec_tick → timer −1.
  - pass_evt and the final sec_tick in the same cycle: pass wins.
  - entry_req and exit_req are ignored while open.
- ALARM:
  - gate_open=0, alarm=1, count unchanged.
  - alarm_clr → IDLE; alarm drops the next cycle.
  - pass_evt in ALARM is ignored.
- Count:
  - Never exceeds CAPACITY; never underflows.
  - Saturation is guaranteed by the IDLE guards and additionally enforced at the adder.
  - full is registered, updated in the same cycle as count.
- Lamp:
  - IDLE: lamp=full, steady.
  - Open states and ALARM: lamp toggles on each half_tick, giving 1 Hz blink.
  - Forced to 0 on entry to IDLE when not full.
- Reset mid-operation: immediate return to reset values; gate closes asynchronously; no count preservation.

Test Plan:
- Reset sequence: reset=1 for 50 ns with clk running → all outputs 0, state IDLE. After release, a held-low clk_1Hz produces no sec_tick.
- Tick latency: clk_1Hz rises → sec_tick high for exactly 1 cycle, 3 cycles later. clk_2Hz at twice the rate → lamp toggles twice per sec_tick while the gate is open.
- Normal entry: entry_req, then pass_evt after 2 sec_ticks → gate_open 1→0, count 0→1, alarm stays 0. Repeat 8 times → count=8, full=1, lamp=1. Ninth entry_req → deny pulse, gate stays closed.
- Timeout: entry_req with no pass → ALARM after the 5th sec_tick, gate_open=0, alarm=1, lamp blinking, count unchanged. alarm_clr → IDLE, alarm=0.
- Priority and corner cases:
  - entry_req and exit_req together with count=3 → EXIT_OPEN; pass → count=2.
  - exit_req with count=0 → stays IDLE.
  - pass_evt coincident with the final sec_tick → count updates, no alarm.
- Async reset mid-open: assert reset while gate_open=1, count=4 → gate_open=0 and count=0 immediately, without waiting for a clk edge.
